gemm_result_writeback: RTL and testbench

//  Downstream stage of the GEMM MAC datapath. Consumes the signed dot-product stream from the
//  vec-mat add stage, sums NUM_TILES consecutive partial results per output element, saturates
//  the sum to DATA_WIDTH and writes it to the output spram. Walks start_addr..end_addr, then

---
 rtl/gemm_pkg.sv | 24 ++
 rtl/gemm_sat.sv | 26 ++
 rtl/gemm_result_writeback.sv | 123 ++++++++++++
 tb/tb_gemm_result_writeback.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// ============================================================================
// gemm_pkg : shared widths, FSM encoding and saturation limits for writeback
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gemm_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage

`default_nettype wire

// File: rtl/gemm_sat.sv
// ============================================================================
// gemm_sat : combinational ACC_WIDTH -> DATA_WIDTH signed saturator
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gemm_sat
  import gemm_pkg::*;
#(
  parameter int ACC_WIDTH = 32
) (
  input  logic [ACC_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  ovf
);

  // The value fits iff every bit from the output sign bit upward is identical.
  logic [ACC_WIDTH-DATA_WIDTH:0] hi_bits;

  assign hi_bits = din[ACC_WIDTH-1:DATA_WIDTH-1];
  assign ovf     = ~((&hi_bits) | (~|hi_bits));
  assign dout    = ovf ? (din[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX) : din[DATA_WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/gemm_result_writeback.sv
// ============================================================================
// gemm_result_writeback : sums NUM_TILES partials per element, saturates, writes spram
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gemm_result_writeback
  import gemm_pkg::*;
#(
  parameter int NUM_TILES = 4,
  parameter int ACC_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sat_flag
);

  localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

  state_t                  state;
  logic [ACC_WIDTH-1:0]    acc;
  logic [TILE_W-1:0]       tile_cnt;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [ADDR_WIDTH-1:0]   end_reg;

  logic                    beat;
  logic [ACC_WIDTH-1:0]    sum;
  logic [DATA_WIDTH-1:0]   sat_data;
  logic                    sat_ovf;

  assign beat = in_valid & in_ready;
  assign sum  = acc + ACC_WIDTH'($signed(in_data));

  gemm_sat #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat (
    .din  (sum),
    .dout (sat_data),
    .ovf  (sat_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      tile_cnt <= '0;
      cur_addr <= '0;
      end_reg  <= '0;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cur_addr <= start_addr;
            end_reg  <= end_addr;
            acc      <= '0;
            tile_cnt <= '0;
            sat_flag <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= ACCUM;
          end
        end

        ACCUM: begin
          if (beat) begin
            if (tile_cnt == LAST_TILE) begin
              wr_en    <= 1'b1;
              wr_addr  <= cur_addr;
              wr_data  <= sat_data;
              sat_flag <= sat_flag | sat_ovf;
              in_ready <= 1'b0;
              state    <= WRITE;
            end else begin
              acc      <= sum;
              tile_cnt <= tile_cnt + TILE_W'(1);
            end
          end
        end

        WRITE: begin
          wr_en    <= 1'b0;
          acc      <= '0;
          tile_cnt <= '0;
          if (cur_addr == end_reg) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            // Address wraps naturally through the top of the spram.
            cur_addr <= cur_addr + ADDR_WIDTH'(1);
            in_ready <= 1'b1;
            state    <= ACCUM;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gemm_result_writeback.sv
// ============================================================================
// tb_gemm_result_writeback : randomized bench with scoreboard for result writeback
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gemm_result_writeback;

  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  start_addr;
  logic [6:0]  end_addr;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        sat_flag;

  gemm_result_writeback #(
    .NUM_TILES (NT),
    .ACC_WIDTH (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int sat16(input longint s);
    if (s > 32767)  return 32'h7FFF;
    if (s < -32768) return 32'h8000;
    return int'(s) & 32'hFFFF;
  endfunction

  // Scoreboard of expected writes, filled from the element sums of each run
  int exp_addr_q[$];
  int exp_data_q[$];
  int exp_wr_cyc  = -1;
  int last_wr_cyc = -1;
  int last_data   = -1;
  int last_addr   = -1;

  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_addr_q.size() == 0) begin
        check_val("unexpected_write", {25'b0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        check_val("wr_addr", {25'b0, wr_addr}, exp_addr_q.pop_front());
        check_val("wr_data", {16'b0, wr_data}, exp_data_q.pop_front());
        check_val("ready_low_in_write", {31'b0, in_ready}, 0);
        check_val("busy_in_write", {31'b0, busy}, 1);
        check_val("write_latency", cyc, exp_wr_cyc);
      end
      last_wr_cyc = cyc;
      last_data   = int'(wr_data);
      last_addr   = int'(wr_addr);
    end
  end

  // mode 0: random values, 1: constant val, 2: val, val+1, val+2, ...
  task automatic run_case(input logic [6:0] sa, input logic [6:0] ea, input int mode,
                          input int val, input int gap_pct, input bit poke_start);
    int     n;
    int     total;
    int     beats[$];
    longint s;
    int     exp_sat;
    int     idx;
    int     guard;
    bit     v;

    n       = ((int'(ea) - int'(sa) + 128) % 128) + 1;
    total   = n * NT;
    exp_sat = 0;
    beats.delete();
    for (int i = 0; i < total; i++) begin
      case (mode)
        1:       beats.push_back(val);
        2:       beats.push_back(val + i);
        default: beats.push_back($urandom_range(1) ? int'($urandom_range(4000)) - 2000
                                                   : int'($urandom_range(65535)) - 32768);
      endcase
    end
    for (int e = 0; e < n; e++) begin
      s = 0;
      for (int j = 0; j < NT; j++) s += longint'(beats[e*NT + j]);
      if (s > 32767 || s < -32768) exp_sat = 1;
      exp_addr_q.push_back((int'(sa) + e) % 128);
      exp_data_q.push_back(sat16(s));
    end

    @(negedge clk);
    start_addr = sa;
    end_addr   = ea;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("start_done_drop", {31'b0, done}, 0);
    check_val("start_busy", {31'b0, busy}, 1);
    check_val("start_sat_clear", {31'b0, sat_flag}, 0);

    idx   = 0;
    guard = 0;
    while (idx < total && guard < 20000) begin
      v        = ($urandom_range(99) >= gap_pct);
      in_valid = v;
      in_data  = 16'(beats[idx]);
      if (poke_start && $urandom_range(9) == 0) begin
        start      = 1'b1;
        start_addr = 7'($urandom);
        end_addr   = 7'($urandom);
      end else begin
        start = 1'b0;
      end
      if (v && in_ready) begin
        if ((idx % NT) == NT - 1) exp_wr_cyc = cyc + 1;
        idx++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check_val("feed_timeout", idx, total);

    guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_val("done_seen", {31'b0, done}, 1);
    check_val("done_latency", cyc - last_wr_cyc, 1);
    check_val("writes_left", exp_addr_q.size(), 0);
    check_val("sat_flag", {31'b0, sat_flag}, exp_sat);
    check_val("busy_after", {31'b0, busy}, 0);
    check_val("ready_after", {31'b0, in_ready}, 0);
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    end_addr   = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", {31'b0, busy}, 0);
    check_val("rst_done", {31'b0, done}, 0);
    check_val("rst_wr_en", {31'b0, wr_en}, 0);
    check_val("rst_ready", {31'b0, in_ready}, 0);
    check_val("rst_sat", {31'b0, sat_flag}, 0);
    check_val("rst_wr_data", {16'b0, wr_data}, 0);
    reset = 1'b0;

    // Abort after two beats: no write may ever appear for address 9
    @(negedge clk);
    start_addr = 7'd9;
    end_addr   = 7'd9;
    start      = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'd100;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check_val("abort_busy", {31'b0, busy}, 0);
    check_val("abort_done", {31'b0, done}, 0);
    check_val("abort_wr_en", {31'b0, wr_en}, 0);
    check_val("abort_ready", {31'b0, in_ready}, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    run_case(7'd0, 7'd0, 2, 1, 0, 1'b0);
    check_val("single_data", last_data, 10);
    check_val("single_addr", last_addr, 0);

    run_case(7'd5, 7'd7, 1, 1, 40, 1'b1);
    check_val("gap_last_data", last_data, 4);

    run_case(7'd3, 7'd3, 1, 16'sh7000, 0, 1'b0);
    check_val("pos_sat_data", last_data, 32'h7FFF);
    run_case(7'd4, 7'd4, 1, -32768, 0, 1'b0);
    check_val("neg_sat_data", last_data, 32'h8000);
    run_case(7'd20, 7'd21, 2, 100, 20, 1'b0);

    run_case(7'd126, 7'd1, 0, 0, 25, 1'b1);
    check_val("wrap_last_addr", last_addr, 1);

    for (int r = 0; r < 6; r++) begin
      logic [6:0] sa;
      sa = 7'($urandom);
      run_case(sa, sa + 7'($urandom_range(5)), 0, 0, 30, 1'b1);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
